// File: rtl/pipelined_adder_n_pkg.sv
// rtl/pipelined_adder_n_pkg.sv - shared defaults and chunk sizing for the pipelined adder
package pipelined_adder_n_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipelined_adder_n_if.sv
// rtl/pipelined_adder_n_if.sv - operand/result handshake bundle of the pipelined adder
interface pipelined_adder_n_if #(
  parameter int WIDTH = pipelined_adder_n_pkg::DEFAULT_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;

  modport master (
    output in_valid, A, B, Cin, Sub, out_ready,
    input  in_ready, out_valid, Sum, Cout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, Sub, out_ready,
    output in_ready, out_valid, Sum, Cout, Ovf
  );

endinterface

// File: rtl/pipelined_adder_n_adder_chunk.sv
// rtl/pipelined_adder_n_adder_chunk.sv - combinational CW-bit ripple adder slice
module adder_chunk #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          ci,
  output logic [CW-1:0] s,
  output logic          co,
  output logic          c_msb_in
);

  always_comb begin
    logic [CW:0] c;
    c        = '0;
    s        = '0;
    c[0]     = ci;
    for (int i = 0; i < CW; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co       = c[CW];
    c_msb_in = c[CW-1];
  end

endmodule

// File: rtl/pipelined_adder_n.sv
// rtl/pipelined_adder_n.sv - WIDTH-bit add/subtract split into STAGES registered ripple chunks
module pipelined_adder_n
  import pipelined_adder_n_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic                clk,
  input  logic                rst,
  pipelined_adder_n_if.slave  bus
);

  localparam int CW = chunk_width(WIDTH, STAGES);

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder_n: WIDTH must be a positive multiple of STAGES");
  end

  logic             en;
  logic             out_valid;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Subtraction is A + ~B + ~Cin, so Cin acts as a borrow-in.
  assign b_eff = bus.Sub ? ~bus.B : bus.B;
  assign c0    = bus.Cin ^ bus.Sub;

  // A held result freezes the whole pipe; bubbles are never squeezed out.
  assign en           = ~(out_valid & ~bus.out_ready);
  assign bus.in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int PW = WIDTH - k * CW;
    localparam int DW = (k + 1) * CW;

    logic [PW-1:0] a_pend;
    logic [PW-1:0] b_pend;
    logic          c_in;
    logic          v_in;
    logic [CW-1:0] s_chunk;
    logic          co;
    logic          c_top;
    logic [DW-1:0] s_next;
    logic [DW-1:0] s_q;
    logic          c_q;
    logic          v_q;

    if (k == 0) begin : g_head
      assign a_pend = bus.A;
      assign b_pend = b_eff;
      assign c_in   = c0;
      assign v_in   = bus.in_valid;
      assign s_next = s_chunk;
    end else begin : g_body
      assign a_pend = g_stage[k-1].g_fwd.a_q;
      assign b_pend = g_stage[k-1].g_fwd.b_q;
      assign c_in   = g_stage[k-1].c_q;
      assign v_in   = g_stage[k-1].v_q;
      assign s_next = {s_chunk, g_stage[k-1].s_q};
    end

    adder_chunk #(.CW(CW)) u_chunk (
      .a        (a_pend[CW-1:0]),
      .b        (b_pend[CW-1:0]),
      .ci       (c_in),
      .s        (s_chunk),
      .co       (co),
      .c_msb_in (c_top)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (en) begin
        v_q <= v_in;
        c_q <= co;
        s_q <= s_next;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      // Only the operand chunks later stages still need are carried forward.
      logic [PW-CW-1:0] a_q;
      logic [PW-CW-1:0] b_q;
      logic             unused_c_top;

      assign unused_c_top = c_top;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_pend[PW-1:CW];
          b_q <= b_pend[PW-1:CW];
        end
      end
    end else begin : g_last
      logic ovf_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= c_top ^ co;
        end
      end
    end
  end

  assign out_valid     = g_stage[STAGES-1].v_q;
  assign bus.out_valid = out_valid;
  assign bus.Sum       = g_stage[STAGES-1].s_q;
  assign bus.Cout      = g_stage[STAGES-1].c_q;
  assign bus.Ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule
